// File: rtl/extended_gcd_inverse_unit.sv
// rtl/extended_gcd_inverse_unit.sv - binary extended GCD / modular inverse engine
// One binary-GCD step per clock; degenerate operands skip straight to FINISH.
module extended_gcd_inverse_unit #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [WORD_WIDTH-1:0]        x,
  input  logic [WORD_WIDTH-1:0]        y,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [WORD_WIDTH-1:0]        gcd_result,
  output logic signed [WORD_WIDTH:0]   coeff_a,
  output logic signed [WORD_WIDTH:0]   coeff_b,
  output logic [WORD_WIDTH-1:0]        inverse
);
  localparam int W  = WORD_WIDTH;
  localparam int GW = $clog2(W) + 1;
  localparam logic signed [W+1:0] S_ONE = {{(W+1){1'b0}}, 1'b1};
  localparam logic [W-1:0]        U_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, STRIP2, REDUCE, FINISH} state_t;
  state_t state_q;

  logic [W-1:0]        u_q, v_q, u_d, v_d, xp_q, yp_q;
  logic signed [W+1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic [GW-1:0]       g_q;
  logic                mode_q, force_err_q;

  logic signed [W+1:0] xs, ys, norm1, norm2;
  logic [W-1:0]        gcd_w;
  logic                gcd_is_one, inv_err;
  logic                unused_bits;

  // Invariants kept by the step: A*x' + B*y' = u and C*x' + D*y' = v.
  always_comb begin
    xs  = $signed({2'b00, xp_q});
    ys  = $signed({2'b00, yp_q});
    u_d = u_q;
    v_d = v_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    if (!u_q[0]) begin
      u_d = u_q >> 1;
      if (!a_q[0] && !b_q[0]) begin
        a_d = a_q >>> 1;
        b_d = b_q >>> 1;
      end else begin
        a_d = (a_q + ys) >>> 1;
        b_d = (b_q - xs) >>> 1;
      end
    end else if (!v_q[0]) begin
      v_d = v_q >> 1;
      if (!c_q[0] && !d_q[0]) begin
        c_d = c_q >>> 1;
        d_d = d_q >>> 1;
      end else begin
        c_d = (c_q + ys) >>> 1;
        d_d = (d_q - xs) >>> 1;
      end
    end else if (u_q >= v_q) begin
      u_d = u_q - v_q;
      a_d = a_q - c_q;
      b_d = b_q - d_q;
    end else begin
      v_d = v_q - u_q;
      c_d = c_q - a_q;
      d_d = d_q - b_q;
    end
  end

  // |C| <= y, so two conditional corrections land the inverse in [1, y-1].
  always_comb begin
    if (c_q[W+1])       norm1 = c_q + ys;
    else if (c_q >= ys) norm1 = c_q - ys;
    else                norm1 = c_q;
    if (norm1[W+1])       norm2 = norm1 + ys;
    else if (norm1 >= ys) norm2 = norm1 - ys;
    else                  norm2 = norm1;
  end

  assign gcd_w       = v_q << g_q;
  assign gcd_is_one  = (gcd_w == U_ONE);
  assign inv_err     = force_err_q || !gcd_is_one;
  assign unused_bits = ^{d_q[W+1], norm2[W+1:W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      u_q         <= '0;
      v_q         <= '0;
      xp_q        <= '0;
      yp_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      g_q         <= '0;
      mode_q      <= 1'b0;
      force_err_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      gcd_result  <= '0;
      coeff_a     <= '0;
      coeff_b     <= '0;
      inverse     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            error       <= 1'b0;
            mode_q      <= mode;
            g_q         <= '0;
            xp_q        <= x;
            yp_q        <= y;
            c_q         <= '0;
            d_q         <= '0;
            force_err_q <= (x == '0 && y == '0) || (mode && y[W-1:1] == '0);
            if (x == '0 && y == '0) begin
              v_q     <= '0;
              state_q <= FINISH;
            end else if (x == '0) begin
              v_q     <= y;
              d_q     <= S_ONE;
              state_q <= FINISH;
            end else if (y == '0) begin
              v_q     <= x;
              c_q     <= S_ONE;
              state_q <= FINISH;
            end else if (mode && y == U_ONE) begin
              v_q     <= U_ONE;
              d_q     <= S_ONE;
              state_q <= FINISH;
            end else begin
              u_q     <= x;
              v_q     <= y;
              state_q <= STRIP2;
            end
          end
        end
        STRIP2: begin
          if (!u_q[0] && !v_q[0]) begin
            u_q <= u_q >> 1;
            v_q <= v_q >> 1;
            g_q <= g_q + 1'b1;
          end else begin
            xp_q    <= u_q;
            yp_q    <= v_q;
            a_q     <= S_ONE;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= S_ONE;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          u_q <= u_d;
          v_q <= v_d;
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          d_q <= d_d;
          if (u_d == '0) state_q <= FINISH;
        end
        FINISH: begin
          gcd_result <= gcd_w;
          if (mode_q) begin
            coeff_a <= '0;
            coeff_b <= '0;
            error   <= inv_err;
            inverse <= inv_err ? '0 : norm2[W-1:0];
          end else begin
            coeff_a <= c_q[W:0];
            coeff_b <= d_q[W:0];
            error   <= force_err_q;
            inverse <= '0;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_extended_gcd_inverse_unit.sv
// tb/tb_extended_gcd_inverse_unit.sv - randomized self-checking bench for extended_gcd_inverse_unit
// Results are checked against plain Euclid / extended Euclid arithmetic held in the bench.
module tb_extended_gcd_inverse_unit;
  localparam int W       = 32;
  localparam int MAX_LAT = 5 * W + 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic busy, done, error;
  logic [W-1:0] gcd_result, inverse;
  logic signed [W:0] coeff_a, coeff_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
  } op_t;
  op_t q[$];

  extended_gcd_inverse_unit #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .x(x), .y(y),
    .busy(busy), .done(done), .error(error), .gcd_result(gcd_result),
    .coeff_a(coeff_a), .coeff_b(coeff_b), .inverse(inverse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected less", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mgcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [W-1:0] minv(input logic [W-1:0] a, input logic [W-1:0] m);
    longint r0, r1, t0, t1, qq, tmp;
    r0 = longint'(m);
    r1 = longint'(a % m);
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      qq  = r0 / r1;
      tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
      tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
    end
    if (r0 != 1) return '0;
    if (t0 < 0) t0 = t0 + longint'(m);
    return W'(t0);
  endfunction

  // Every done pulse is matched against the oldest launched operation.
  always @(negedge clk) begin : cmp
    op_t e;
    logic [W-1:0] eg, einv;
    bit eerr, spec;
    int lat;
    logic signed [127:0] sa, sb, sx, sy, lhs, abs_a, abs_b;
    if (reset && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", q.size() != 0, longint'(done), 0);
      end else begin
        e    = q.pop_front();
        eg   = mgcd(e.a, e.b);
        eerr = e.m ? (e.b < 2 || eg != 1) : (e.a == '0 && e.b == '0);
        einv = (e.m && !eerr) ? minv(e.a, e.b) : '0;
        spec = (e.a == '0) || (e.b == '0) || (e.m && e.b < 2);
        lat  = cyc - e.acc + 1;
        check("busy_at_done", busy == 1'b0, longint'(busy), 0);
        if (spec) check("latency_special", lat == 2, longint'(lat), 2);
        else      check("latency", lat <= MAX_LAT, longint'(lat), MAX_LAT);
        check("error", error == eerr, longint'(error), longint'(eerr));
        check("gcd", gcd_result == eg, longint'(gcd_result), longint'(eg));
        if (e.m) begin
          check("coeff_zero", coeff_a == 0 && coeff_b == 0, longint'(coeff_a), 0);
          check("inverse", inverse == einv, longint'(inverse), longint'(einv));
        end else begin
          sa  = 128'(coeff_a);
          sb  = 128'(coeff_b);
          sx  = 128'(e.a);
          sy  = 128'(e.b);
          lhs = sa * sx + sb * sy;
          check("bezout", lhs == 128'(eg), longint'(lhs[63:0]), longint'(eg));
          check("inverse_zero_gcd_mode", inverse == '0, longint'(inverse), 0);
          if (e.a != '0 && e.b != '0) begin
            abs_a = (sa < 0) ? -sa : sa;
            abs_b = (sb < 0) ? -sb : sb;
            check("bound_a", abs_a <= sy, longint'(abs_a[63:0]), longint'(e.b));
            check("bound_b", abs_b <= sx, longint'(abs_b[63:0]), longint'(e.a));
          end
        end
      end
    end
  end

  task automatic launch_now(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t e;
    start = 1'b1; mode = m; x = a; y = b;
    @(posedge clk); #1;
    e.m = m; e.a = a; e.b = b; e.acc = cyc;
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic launch(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    launch_now(m, a, b);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < MAX_LAT + 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, longint'(seen), 1);
    if (!seen) q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_zero"}, {busy, done, error, gcd_result, coeff_a, coeff_b, inverse} == '0,
          longint'({busy, done, error}) | longint'(gcd_result), 0);
  endtask

  initial begin
    longint prod;
    int ks[7] = '{2, 4, 6, 10, 16, 100, 1000};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    launch(1'b0, 693, 609); wait_done();
    check("lit_gcd_693_609", gcd_result == 21, longint'(gcd_result), 21);

    launch(1'b1, 17, 3120); wait_done();
    check("lit_inv_17_3120", inverse == 2753, longint'(inverse), 2753);

    launch(1'b1, 6, 9); wait_done();
    check("lit_err_6_9", error == 1'b1 && inverse == '0 && gcd_result == 3,
          longint'(gcd_result), 3);

    launch(1'b0, 0, 0); wait_done();
    check("lit_zero_zero", error == 1'b1 && gcd_result == '0, longint'(error), 1);

    launch(1'b0, 0, 12); wait_done();
    check("lit_0_12", gcd_result == 12 && coeff_a == 0 && coeff_b == 1,
          longint'(coeff_b), 1);

    launch(1'b0, 32'h8000_0000, 32'h0010_0000); wait_done();
    check("lit_pow2", gcd_result == 32'h0010_0000, longint'(gcd_result), 1048576);

    foreach (ks[i]) begin
      launch(1'b1, 65537, 32'(3233 * ks[i])); wait_done();
      prod = (longint'(65537) * longint'(inverse)) % longint'(3233 * ks[i]);
      check("rsa_inverse", prod == 1 && error == 1'b0, prod, 1);
    end

    launch(1'b1, 5, 1); wait_done();
    launch(1'b1, 5, 0); wait_done();

    // Handshake: a start while busy is ignored, a start in the done cycle is taken.
    launch(1'b0, 693, 609);
    repeat (3) @(negedge clk);
    start = 1'b1; x = 5; y = 7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("lit_busy_start_ignored", gcd_result == 21, longint'(gcd_result), 21);
    launch_now(1'b0, 5, 7);
    wait_done();
    check("lit_done_cycle_start", gcd_result == 1, longint'(gcd_result), 1);
    repeat (20) @(negedge clk);

    // Reset in the middle of an operation.
    launch(1'b0, 693, 609);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("midop_reset");
    q.delete();
    repeat (3) @(negedge clk);
    check_zero("held_reset");
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_after_reset", busy == 1'b0 && done == 1'b0, longint'(busy), 0);
    launch(1'b0, 693, 609); wait_done();
    check("lit_after_reset", gcd_result == 21, longint'(gcd_result), 21);

    for (int i = 0; i < 60; i++) begin
      logic rm;
      logic [W-1:0] ra, rb;
      rm = ($urandom_range(0, 1) != 0);
      ra = $urandom >> $urandom_range(0, W - 1);
      rb = $urandom >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      if ($urandom_range(0, 1) == 1) launch_now(rm, ra, rb);
      else                           launch(rm, ra, rb);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/extended_gcd_inverse_unit.md
# extended_gcd_inverse_unit

Parametrised extended binary GCD engine with a start/busy/done handshake and two modes: plain GCD with Bézout coefficients, or modular inverse with a range-normalised result and an error flag. It sits in the RSA key-generation path to compute the private exponent d = e⁻¹ mod φ(n), where φ(n) is even. It also serves as a general GCD checker for candidate public exponents. One binary-GCD step runs per clock, and the unit accepts a new operation only when idle.

## Interface
- WORD_WIDTH, 32: operand width in bits, ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; when low, all state and outputs clear.
- start  input  1  request, sampled only while busy = 0.
- mode  input  1  0 = GCD, 1 = modular inverse of x mod y; captured with start.
- x  input  WORD_WIDTH  operand (unsigned), captured with start.
- y  input  WORD_WIDTH  operand / modulus (unsigned), captured with start.
- busy  output  1  high from the cycle after accepted start until the cycle done pulses.
- done  output  1  single-cycle pulse when results are valid.
- error  output  1  valid with done; held until the next accepted start.
- gcd_result  output  WORD_WIDTH  gcd(x, y).
- coeff_a, coeff_b  output  signed WORD_WIDTH+1  values with a·x + b·y = gcd (GCD mode only; 0 in inverse mode).
- inverse  output  WORD_WIDTH  x⁻¹ mod y, in range [1, y−1] (inverse mode, error = 0); otherwise 0.

## Operation
- The algorithm is binary extended Euclid (HAC 14.61).
- Internal u, v are unsigned WORD_WIDTH. The coefficient registers A, B, C, D are signed WORD_WIDTH+2. g is a shift count.
- States: IDLE → STRIP2 → REDUCE → FINISH → IDLE.
- Special cases are handled in IDLE on start and go straight to FINISH:
  - x = y = 0: gcd = 0, error = 1.
  - x = 0: gcd = y, coefficients (0, 1).
  - y = 0: gcd = x, coefficients (1, 0).
  - In inverse mode, y < 2 gives error = 1.
- STRIP2: while both operands are even, shift both right by 1 and increment g; one shift per cycle. Then load u = x', v = y', A = 1, B = 0, C = 0, D = 1.
- REDUCE performs one action per cycle, in this priority:
  - u even: u >>= 1. If A and B are both even, A >>= 1 and B >>= 1 (arithmetic). Otherwise A = (A + y')>>1 and B = (B − x')>>1.
  - else v even: the same rule applied to v, C, D.
  - else u ≥ v: u −= v, A −= C, B −= D.
  - else: v −= u, C −= A, D −= B.
  - Exit when u = 0.
- FINISH (one cycle):
  - gcd_result = v << g; coeff_a = C; coeff_b = D.
  - Inverse mode: error = (gcd ≠ 1). When error = 0, inverse = C mod y, normalised by adding or subtracting y at most twice so the result lies in [1, y−1].
  - done pulses and the state returns to IDLE.
- Outputs hold their values until the next accepted start. At that start, done and error clear, and the result outputs are not updated until the next done.
- start while busy = 1 is ignored: no recapture, no effect on the in-flight operation.
- Internal arithmetic must not overflow at WORD_WIDTH+2. |C| ≤ y and |D| ≤ x hold throughout, and the output width must hold these bounds.

## Timing
- Reset value of every output is 0; the state is IDLE.
- Reset assertion mid-operation aborts the operation immediately. No done pulse is produced, and the unit is idle on the first clock after release.
- An accepted start at edge N gives busy = 1 from N+1.
- done = 1 for exactly one cycle. busy = 0 in that same cycle, so a new start is accepted in the done cycle.
- Special cases: done at N+2.
- General latency: at most 5·WORD_WIDTH + 4 cycles from start to done.
- start held high continuously re-launches an operation on each done cycle.

## Test plan
- GCD mode, x = 693, y = 609 → gcd_result = 21. Check 693·coeff_a + 609·coeff_b = 21, |coeff_a| ≤ 609, |coeff_b| ≤ 693, error = 0. Latency must be ≤ 164 cycles.
- Inverse mode, x = 17, y = 3120 → inverse = 2753, error = 0. Repeat with x = 65537, y = 3233·k for a set of even moduli and check (x·inverse) mod y = 1.
- Error and special cases:
  - Inverse mode, x = 6, y = 9 → error = 1, inverse = 0, gcd_result = 3.
  - GCD mode, x = 0, y = 0 → gcd_result = 0, error = 1, done at N+2.
  - GCD mode, x = 0, y = 12 → gcd_result = 12, coefficients (0, 1).
- Powers of two: GCD mode, x = 2^31, y = 2^20 → gcd_result = 2^20, g = 20 shifts. The Bézout identity holds.
- Handshake: pulse start with x = 693, y = 609; 3 cycles later pulse start with x = 5, y = 7 → the first result (21) is returned, with exactly one done pulse. A new start in the done cycle is accepted.
- Reset mid-operation: assert reset 10 cycles after start → all outputs 0 while reset is low. No done pulse appears. The next start completes normally with correct results.
